tff_toggle_decoder: RTL and testbench

- Receive end of the T-flip-flop toggle path: takes the serial Q stream that a T flip-flop produces and recovers the original T (toggle) bits, using T = Q xor Q_prev.
- Packs the recovered bits LSB-first into WIDTH-bit words.
- Delivers each word through a one-entry output register with a valid/ready handshake.
- Sits between the T-FF datapath and any word-level consumer or self-checking logic.

---
 rtl/tff_pkg.sv | 16 +
 rtl/tff_diff.sv | 25 ++
 rtl/tff_toggle_decoder.sv | 114 +++++++++++
 tb/tb_tff_toggle_decoder.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tff_pkg.sv
// Shared types and helpers for the T flip-flop toggle path.
package tff_pkg;

    localparam int TFF_WORD_W_DEFAULT = 8;

    typedef enum logic {
        OB_EMPTY = 1'b0,
        OB_FULL  = 1'b1
    } ob_state_t;

    // Counter width that never collapses to zero bits.
    function automatic int cnt_w(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/tff_diff.sv
// Inverse of a T flip-flop: recovers the toggle bit as q xor previous q.
module tff_diff (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    input  logic q,
    output logic t_bit
);

    logic prev_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q <= 1'b0;
        end else if (clr) begin
            prev_q <= 1'b0;
        end else if (en) begin
            prev_q <= q;
        end
    end

    assign t_bit = q ^ prev_q;

endmodule

// File: rtl/tff_toggle_decoder.sv
// Recovers T bits from a serial Q stream, packs them LSB-first into words,
// and presents each word through a one-entry valid/ready output register.
//   state    | meaning
//   OB_EMPTY | output register holds no unconsumed word
//   OB_FULL  | t_word is valid and waiting for t_ready
module tff_toggle_decoder
    import tff_pkg::*;
#(
    parameter int WIDTH = TFF_WORD_W_DEFAULT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      q_in,
    input  logic                      q_valid,
    input  logic                      sync_clr,
    output logic [WIDTH-1:0]          t_word,
    output logic                      t_valid,
    input  logic                      t_ready,
    output logic [cnt_w(WIDTH)-1:0]   bit_cnt,
    output logic                      overflow
);

    localparam int CW = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    ob_state_t        state_q, state_d;
    logic             t_bit;
    logic             accept;
    logic             word_done;
    logic             out_free;
    logic             load;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] word_next;

    tff_diff u_diff (
        .clk   (clk),
        .reset (reset),
        .clr   (sync_clr),
        .en    (q_valid),
        .q     (q_in),
        .t_bit (t_bit)
    );

    // sync_clr wins over a same-cycle valid bit; that bit is discarded.
    assign accept    = q_valid & ~sync_clr;
    assign word_done = accept & (bit_cnt == LAST_IDX);
    assign out_free  = (state_q == OB_EMPTY) | t_ready;
    assign load      = word_done & out_free;

    always_comb begin
        word_next          = shreg;
        word_next[bit_cnt] = t_bit;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (sync_clr) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (accept) begin
            if (word_done) begin
                shreg   <= '0;
                bit_cnt <= '0;
            end else begin
                shreg   <= word_next;
                bit_cnt <= bit_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (sync_clr) begin
            overflow <= 1'b0;
        end else if (word_done && !out_free) begin
            overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= OB_EMPTY;
            t_word  <= '0;
        end else begin
            state_q <= state_d;
            if (load) begin
                t_word <= word_next;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        t_valid = 1'b0;
        case (state_q)
            OB_EMPTY: begin
                if (load) begin
                    state_d = OB_FULL;
                end
            end
            OB_FULL: begin
                t_valid = 1'b1;
                if (t_ready && !load) begin
                    state_d = OB_EMPTY;
                end
            end
            default: state_d = OB_EMPTY;
        endcase
    end

endmodule

// File: tb/tb_tff_toggle_decoder.sv
// Self-checking bench for tff_toggle_decoder: vector table, corner-case
// sequences and a randomized run against a queue-based reference model.
module tb_tff_toggle_decoder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         q_in = 1'b0;
    logic         q_valid = 1'b0;
    logic         sync_clr = 1'b0;
    logic         t_ready = 1'b0;
    logic [W-1:0] t_word;
    logic         t_valid;
    logic [2:0]   bit_cnt;
    logic         overflow;

    int errors = 0;
    int checks = 0;

    tff_toggle_decoder #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .q_in     (q_in),
        .q_valid  (q_valid),
        .sync_clr (sync_clr),
        .t_word   (t_word),
        .t_valid  (t_valid),
        .t_ready  (t_ready),
        .bit_cnt  (bit_cnt),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, then let the edge pass and settle.
    task automatic cyc(input logic qv, input logic q, input logic tr, input logic sc);
        q_valid  = qv;
        q_in     = q;
        t_ready  = tr;
        sync_clr = sc;
        @(posedge clk);
        #1;
    endtask

    // Feed n Q samples, sample i taken from qs[i].
    task automatic feed(input logic [7:0] qs, input int n, input logic tr);
        for (int i = 0; i < n; i++) cyc(1'b1, qs[i], tr, 1'b0);
    endtask

    // ---------------- reference model ----------------
    bit       mq[$];
    bit       m_prev;
    bit [W-1:0] m_word;
    bit       m_valid;
    bit       m_ovf;

    task automatic model_reset();
        mq.delete();
        m_prev  = 0;
        m_word  = '0;
        m_valid = 0;
        m_ovf   = 0;
    endtask

    task automatic model_step(input bit qv, input bit q, input bit tr, input bit sc);
        bit [W-1:0] w;
        if (m_valid && tr) m_valid = 0;
        if (sc) begin
            mq.delete();
            m_prev = 0;
            m_ovf  = 0;
        end else if (qv) begin
            mq.push_back(q ^ m_prev);
            m_prev = q;
            if (mq.size() == W) begin
                w = '0;
                for (int i = 0; i < W; i++) if (mq[i]) w = w | (W'(1) << i);
                if (!m_valid) begin
                    m_word  = w;
                    m_valid = 1;
                end else begin
                    m_ovf = 1;
                end
                mq.delete();
            end
        end
    endtask

    typedef struct {
        logic [7:0] qs;
        logic [7:0] exp_word;
    } vec_t;

    vec_t vecs[7];

    initial begin
        // t = q ^ (q << 1) with the reference starting at 0
        vecs[0] = '{8'h46, 8'hCA};
        vecs[1] = '{8'hFF, 8'h01};
        vecs[2] = '{8'h00, 8'h00};
        vecs[3] = '{8'h55, 8'hFF};
        vecs[4] = '{8'h0F, 8'h11};
        vecs[5] = '{8'hF0, 8'h10};
        vecs[6] = '{8'hAA, 8'hFE};

        // Reset state
        #12;
        chk("rst_t_valid", 32'(t_valid), 32'd0);
        chk("rst_t_word", 32'(t_word), 32'd0);
        chk("rst_bit_cnt", 32'(bit_cnt), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Basic decode with one-cycle valid pulse
        feed(8'h46, 7, 1'b1);
        chk("basic_no_early_valid", 32'(t_valid), 32'd0);
        chk("basic_bit_cnt7", 32'(bit_cnt), 32'd7);
        cyc(1'b1, 1'b0, 1'b1, 1'b0);
        chk("basic_valid", 32'(t_valid), 32'd1);
        chk("basic_word", 32'(t_word), 32'hCA);
        chk("basic_bit_cnt_wrap", 32'(bit_cnt), 32'd0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("basic_valid_one_cycle", 32'(t_valid), 32'd0);

        // Vector table
        foreach (vecs[k]) begin
            cyc(1'b0, 1'b0, 1'b1, 1'b1);
            feed(vecs[k].qs, 8, 1'b1);
            chk($sformatf("vec%0d_valid", k), 32'(t_valid), 32'd1);
            chk($sformatf("vec%0d_word", k), 32'(t_word), 32'(vecs[k].exp_word));
            cyc(1'b0, 1'b0, 1'b1, 1'b0);
            chk($sformatf("vec%0d_drained", k), 32'(t_valid), 32'd0);
        end

        // Gapped input
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) begin
            logic [7:0] s;
            s = 8'h46;
            cyc(1'b1, s[i], 1'b1, 1'b0);
            if (i == 7) begin
                chk("gap_valid", 32'(t_valid), 32'd1);
                chk("gap_word", 32'(t_word), 32'hCA);
            end
            chk($sformatf("gap_cnt_%0d", i), 32'(bit_cnt), 32'((i + 1) % 8));
            for (int g = 0; g < 3; g++) cyc(1'b0, 1'b1, 1'b1, 1'b0);
            chk($sformatf("gap_cnt_hold_%0d", i), 32'(bit_cnt), 32'((i + 1) % 8));
        end

        // Backpressure and overflow
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        feed(8'h46, 8, 1'b0);
        chk("bp_first_valid", 32'(t_valid), 32'd1);
        chk("bp_first_ovf", 32'(overflow), 32'd0);
        feed(8'hFF, 7, 1'b0);
        chk("bp_ovf_before_last", 32'(overflow), 32'd0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk("bp_ovf_set", 32'(overflow), 32'd1);
        chk("bp_word_held", 32'(t_word), 32'hCA);
        chk("bp_valid_held", 32'(t_valid), 32'd1);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("bp_valid_falls", 32'(t_valid), 32'd0);
        chk("bp_ovf_sticky", 32'(overflow), 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
        chk("bp_ovf_sticky2", 32'(overflow), 32'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("bp_ovf_cleared", 32'(overflow), 32'd0);

        // Simultaneous consume and load
        feed(8'h46, 8, 1'b0);
        feed(8'hFF, 7, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        chk("sim_valid", 32'(t_valid), 32'd1);
        chk("sim_word", 32'(t_word), 32'h01);
        chk("sim_ovf", 32'(overflow), 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("clr_keeps_valid", 32'(t_valid), 32'd1);
        chk("clr_keeps_word", 32'(t_word), 32'h01);
        cyc(1'b0, 1'b0, 1'b1, 1'b1);
        chk("clr_handshake", 32'(t_valid), 32'd0);

        // sync_clr over a same-cycle valid bit
        feed(8'h15, 5, 1'b1);
        chk("sc_cnt5", 32'(bit_cnt), 32'd5);
        cyc(1'b1, 1'b0, 1'b1, 1'b1);
        chk("sc_cnt0", 32'(bit_cnt), 32'd0);
        feed(8'hFF, 8, 1'b1);
        chk("sc_valid", 32'(t_valid), 32'd1);
        chk("sc_word", 32'(t_word), 32'h01);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);

        // Async reset mid-word with a pending word
        feed(8'h46, 8, 1'b0);
        feed(8'hFF, 4, 1'b0);
        chk("ar_pending", 32'(t_valid), 32'd1);
        chk("ar_cnt4", 32'(bit_cnt), 32'd4);
        #3 reset = 1'b1;
        #1;
        chk("ar_valid", 32'(t_valid), 32'd0);
        chk("ar_word", 32'(t_word), 32'd0);
        chk("ar_cnt", 32'(bit_cnt), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        feed(8'h46, 8, 1'b1);
        chk("ar_redecode_valid", 32'(t_valid), 32'd1);
        chk("ar_redecode_word", 32'(t_word), 32'hCA);

        // Randomized run against the reference model
        reset = 1'b1;
        #1;
        model_reset();
        @(posedge clk);
        #1 reset = 1'b0;
        for (int n = 0; n < 600; n++) begin
            bit qv, q, tr, sc;
            qv = ($urandom_range(0, 3) != 0);
            q  = 1'($urandom);
            tr = ($urandom_range(0, 2) != 0);
            sc = ($urandom_range(0, 39) == 0);
            model_step(qv, q, tr, sc);
            cyc(qv, q, tr, sc);
            chk("rnd_valid", 32'(t_valid), 32'(m_valid));
            chk("rnd_word", 32'(t_word), 32'(m_word));
            chk("rnd_cnt", 32'(bit_cnt), 32'(mq.size()));
            chk("rnd_ovf", 32'(overflow), 32'(m_ovf));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
